// File: rtl/rob_pkg.sv
// Shared reorder-buffer definitions: entry layout, field positions, command codes.
package rob_pkg;

  localparam int ROB_SIZE = 32;
  localparam int ENTRY_W  = 78;

  // Bit positions of each field inside a 78-bit entry.
  localparam int CMD_HI     = 77;
  localparam int CMD_LO     = 75;
  localparam int RD_HI      = 74;
  localparam int RD_LO      = 70;
  localparam int FLAGV_BIT  = 69;
  localparam int FLAGD_HI   = 68;
  localparam int FLAGD_LO   = 65;
  localparam int DVALID_BIT = 64;
  localparam int DATA_HI    = 63;
  localparam int DATA_LO    = 0;

  typedef enum logic [2:0] {
    CMD_ALU    = 3'd0,
    CMD_STORE  = 3'd1,
    CMD_BCOND0 = 3'd2,
    CMD_BCOND1 = 3'd3,
    CMD_CBZ0   = 3'd4,
    CMD_CBZ1   = 3'd5,
    CMD_BR     = 3'd6,
    CMD_BL     = 3'd7
  } rob_cmd_e;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [4:0]  rd;
    logic        flag_valid;
    logic [3:0]  flag_data;
    logic        data_valid;
    logic [63:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrap-around ring pointer with synchronous clear, used for ROB head and tail.
module rob_ptr
  import rob_pkg::*;
#(
  parameter int W     = 5,
  parameter int DEPTH = ROB_SIZE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         advance,
  output logic [W-1:0] ptr
);

  localparam logic [W-1:0] LAST = W'(DEPTH - 1);

  // Step the pointer, wrapping after the last entry; clear wins over advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (ptr == LAST) ? '0 : ptr + W'(1);
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocate at tail, complete by tag, commit at head.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int ROBsize  = ROB_SIZE,
  parameter int addrSize = $clog2(ROBsize)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                alloc_valid_i,
  input  logic [2:0]          alloc_cmd_i,
  input  logic [4:0]          alloc_rd_i,
  output logic                alloc_ready_o,
  output logic [addrSize-1:0] alloc_tag_o,
  input  logic                wb_valid_i,
  input  logic [addrSize-1:0] wb_tag_i,
  input  logic [63:0]         wb_data_i,
  input  logic                wb_flagValid_i,
  input  logic [3:0]          wb_flagData_i,
  input  logic                ROBupdateHead_i,
  output logic [addrSize-1:0] ROBhead_o,
  output logic [ENTRY_W-1:0]  ROBcommitReadData_o,
  output logic                headValid_o,
  input  logic                flush_i,
  output logic [addrSize:0]   count_o
);

  localparam logic [addrSize:0] CAPACITY = (addrSize + 1)'(ROBsize);

  // Payload storage; never reset, validity lives in the status vectors.
  logic [2:0]  cmd_mem        [ROBsize];
  logic [4:0]  rd_mem         [ROBsize];
  logic        flag_valid_mem [ROBsize];
  logic [3:0]  flag_data_mem  [ROBsize];
  logic [63:0] data_mem       [ROBsize];

  logic [ROBsize-1:0]  occupied;
  logic [ROBsize-1:0]  data_valid;
  logic [addrSize:0]   count;
  logic [addrSize-1:0] head;
  logic [addrSize-1:0] tail;
  logic                head_valid;
  logic                do_alloc;
  logic                do_wb;
  logic                do_commit;

  // Full/empty come from count only; pointers may be equal in both cases.
  assign head_valid = (count != '0);
  assign alloc_ready_o = (count < CAPACITY);
  assign do_alloc  = alloc_valid_i & alloc_ready_o & ~flush_i;
  assign do_wb     = wb_valid_i & occupied[wb_tag_i] & ~flush_i;
  assign do_commit = ROBupdateHead_i & head_valid & data_valid[head] & ~flush_i;

  rob_ptr #(.W(addrSize), .DEPTH(ROBsize)) u_head_ptr (
    .clk     (clk_i),
    .rst_n   (reset_i),
    .clear   (flush_i),
    .advance (do_commit),
    .ptr     (head)
  );

  rob_ptr #(.W(addrSize), .DEPTH(ROBsize)) u_tail_ptr (
    .clk     (clk_i),
    .rst_n   (reset_i),
    .clear   (flush_i),
    .advance (do_alloc),
    .ptr     (tail)
  );

  // Payload writes: allocation zeroes the result fields, writeback fills them.
  always_ff @(posedge clk_i) begin
    if (do_alloc) begin
      cmd_mem[tail]        <= alloc_cmd_i;
      rd_mem[tail]         <= alloc_rd_i;
      flag_valid_mem[tail] <= 1'b0;
      flag_data_mem[tail]  <= 4'd0;
      data_mem[tail]       <= 64'd0;
    end
    if (do_wb) begin
      flag_valid_mem[wb_tag_i] <= wb_flagValid_i;
      flag_data_mem[wb_tag_i]  <= wb_flagData_i;
      data_mem[wb_tag_i]       <= wb_data_i;
    end
  end

  // Status bits; commit is applied last so it beats a same-entry writeback.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      occupied   <= '0;
      data_valid <= '0;
    end else if (flush_i) begin
      occupied   <= '0;
      data_valid <= '0;
    end else begin
      if (do_alloc) begin
        occupied[tail]   <= 1'b1;
        data_valid[tail] <= 1'b0;
      end
      if (do_wb) begin
        data_valid[wb_tag_i] <= 1'b1;
      end
      if (do_commit) begin
        occupied[head]   <= 1'b0;
        data_valid[head] <= 1'b0;
      end
    end
  end

  // Occupancy: a simultaneous alloc and commit cancel out.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      count <= '0;
    end else if (flush_i) begin
      count <= '0;
    end else if (do_alloc && !do_commit) begin
      count <= count + 1'b1;
    end else if (do_commit && !do_alloc) begin
      count <= count - 1'b1;
    end
  end

  // Zero-latency view of the head entry, forced to zero when empty.
  always_comb begin
    ROBcommitReadData_o = '0;
    if (head_valid) begin
      ROBcommitReadData_o[CMD_HI:CMD_LO]     = cmd_mem[head];
      ROBcommitReadData_o[RD_HI:RD_LO]       = rd_mem[head];
      ROBcommitReadData_o[FLAGV_BIT]         = flag_valid_mem[head];
      ROBcommitReadData_o[FLAGD_HI:FLAGD_LO] = flag_data_mem[head];
      ROBcommitReadData_o[DVALID_BIT]        = data_valid[head];
      ROBcommitReadData_o[DATA_HI:DATA_LO]   = data_mem[head];
    end
  end

  assign alloc_tag_o = tail;
  assign ROBhead_o   = head;
  assign headValid_o = head_valid;
  assign count_o     = count;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with hand-computed expectations.
module tb_reorder_buffer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        alloc_valid_i;
  logic [2:0]  alloc_cmd_i;
  logic [4:0]  alloc_rd_i;
  logic        alloc_ready_o;
  logic [4:0]  alloc_tag_o;
  logic        wb_valid_i;
  logic [4:0]  wb_tag_i;
  logic [63:0] wb_data_i;
  logic        wb_flagValid_i;
  logic [3:0]  wb_flagData_i;
  logic        ROBupdateHead_i;
  logic [4:0]  ROBhead_o;
  logic [77:0] ROBcommitReadData_o;
  logic        headValid_o;
  logic        flush_i;
  logic [5:0]  count_o;

  int vectors = 0;
  int miscompares = 0;

  reorder_buffer dut (
    .clk_i               (clk_i),
    .reset_i             (reset_i),
    .alloc_valid_i       (alloc_valid_i),
    .alloc_cmd_i         (alloc_cmd_i),
    .alloc_rd_i          (alloc_rd_i),
    .alloc_ready_o       (alloc_ready_o),
    .alloc_tag_o         (alloc_tag_o),
    .wb_valid_i          (wb_valid_i),
    .wb_tag_i            (wb_tag_i),
    .wb_data_i           (wb_data_i),
    .wb_flagValid_i      (wb_flagValid_i),
    .wb_flagData_i       (wb_flagData_i),
    .ROBupdateHead_i     (ROBupdateHead_i),
    .ROBhead_o           (ROBhead_o),
    .ROBcommitReadData_o (ROBcommitReadData_o),
    .headValid_o         (headValid_o),
    .flush_i             (flush_i),
    .count_o             (count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [77:0] ent(input logic [2:0] cmd, input logic [4:0] rd,
                                      input logic fv, input logic [3:0] fd,
                                      input logic dv, input logic [63:0] data);
    return {cmd, rd, fv, fd, dv, data};
  endfunction

  task automatic check(input string tag, input logic [77:0] observed, input logic [77:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_i = 1'b0;
    alloc_valid_i = 1'b0; alloc_cmd_i = '0; alloc_rd_i = '0;
    wb_valid_i = 1'b0; wb_tag_i = '0; wb_data_i = '0;
    wb_flagValid_i = 1'b0; wb_flagData_i = '0;
    ROBupdateHead_i = 1'b0; flush_i = 1'b0;
    #1;
    // Outputs during reset
    check("rst_ready", 78'(alloc_ready_o), 78'd1);
    check("rst_tag", 78'(alloc_tag_o), 78'd0);
    check("rst_head", 78'(ROBhead_o), 78'd0);
    check("rst_hvalid", 78'(headValid_o), 78'd0);
    check("rst_count", 78'(count_o), 78'd0);
    check("rst_rdata", ROBcommitReadData_o, 78'd0);
    tick(); tick();
    reset_i = 1'b1;

    // Fill all 32 entries
    alloc_valid_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      alloc_cmd_i = 3'(i % 8);
      alloc_rd_i  = 5'(i);
      check($sformatf("fill_tag%0d", i), 78'(alloc_tag_o), 78'(i));
      tick();
    end
    check("full_count", 78'(count_o), 78'd32);
    check("full_ready", 78'(alloc_ready_o), 78'd0);
    // 33rd alloc is ignored
    tick();
    check("over_count", 78'(count_o), 78'd32);
    check("over_tag", 78'(alloc_tag_o), 78'd0);
    check("over_head", 78'(ROBhead_o), 78'd0);
    alloc_valid_i = 1'b0;

    // Complete head of the full buffer
    wb_valid_i = 1'b1; wb_tag_i = 5'd0; wb_data_i = 64'h1234;
    wb_flagValid_i = 1'b1; wb_flagData_i = 4'hA;
    tick();
    wb_valid_i = 1'b0; wb_flagValid_i = 1'b0; wb_flagData_i = 4'h0;
    check("wb_head_rdata", ROBcommitReadData_o, ent(3'd0, 5'd0, 1'b1, 4'hA, 1'b1, 64'h1234));
    // Alloc + commit while full: commit only
    alloc_valid_i = 1'b1; alloc_cmd_i = 3'd7; alloc_rd_i = 5'd9; ROBupdateHead_i = 1'b1;
    check("full_ready2", 78'(alloc_ready_o), 78'd0);
    tick();
    check("fullcommit_count", 78'(count_o), 78'd31);
    check("fullcommit_head", 78'(ROBhead_o), 78'd1);
    ROBupdateHead_i = 1'b0;
    check("wrap_ready", 78'(alloc_ready_o), 78'd1);
    check("wrap_tag", 78'(alloc_tag_o), 78'd0);
    tick();
    alloc_valid_i = 1'b0;
    check("wrap_count", 78'(count_o), 78'd32);
    check("wrap_tail", 78'(alloc_tag_o), 78'd1);
    check("head1_rdata", ROBcommitReadData_o, ent(3'd1, 5'd1, 1'b0, 4'h0, 1'b0, 64'h0));

    // Flush a full buffer with concurrent alloc and wb
    flush_i = 1'b1; alloc_valid_i = 1'b1; wb_valid_i = 1'b1; wb_tag_i = 5'd5; wb_data_i = 64'hDEAD;
    tick();
    flush_i = 1'b0; alloc_valid_i = 1'b0; wb_valid_i = 1'b0;
    check("flush1_count", 78'(count_o), 78'd0);
    check("flush1_tag", 78'(alloc_tag_o), 78'd0);

    // Out-of-order completion, in-order commit
    alloc_valid_i = 1'b1; alloc_cmd_i = 3'd0; alloc_rd_i = 5'd3;
    tick();
    alloc_cmd_i = 3'd2; alloc_rd_i = 5'd4;
    tick();
    alloc_valid_i = 1'b0;
    wb_valid_i = 1'b1; wb_tag_i = 5'd1; wb_data_i = 64'hAA;
    tick();
    wb_valid_i = 1'b0;
    ROBupdateHead_i = 1'b1;
    tick();
    check("blocked_count", 78'(count_o), 78'd2);
    check("blocked_head", 78'(ROBhead_o), 78'd0);
    wb_valid_i = 1'b1; wb_tag_i = 5'd0; wb_data_i = 64'h55;
    tick();
    wb_valid_i = 1'b0;
    check("wb0_count", 78'(count_o), 78'd2);
    check("wb0_rdata", ROBcommitReadData_o, ent(3'd0, 5'd3, 1'b0, 4'h0, 1'b1, 64'h55));
    tick();
    check("c0_count", 78'(count_o), 78'd1);
    check("c0_head", 78'(ROBhead_o), 78'd1);
    check("c0_rdata", ROBcommitReadData_o, ent(3'd2, 5'd4, 1'b0, 4'h0, 1'b1, 64'hAA));
    tick();
    ROBupdateHead_i = 1'b0;
    check("c1_count", 78'(count_o), 78'd0);
    check("c1_hvalid", 78'(headValid_o), 78'd0);
    check("c1_head", 78'(ROBhead_o), 78'd2);
    check("c1_rdata", ROBcommitReadData_o, 78'd0);

    // Simultaneous alloc and commit in a non-full buffer
    alloc_valid_i = 1'b1; alloc_cmd_i = 3'd1; alloc_rd_i = 5'd1;
    tick(); tick(); tick();
    alloc_valid_i = 1'b0;
    wb_valid_i = 1'b1; wb_tag_i = 5'd2; wb_data_i = 64'h77;
    tick();
    wb_valid_i = 1'b0;
    alloc_valid_i = 1'b1; ROBupdateHead_i = 1'b1;
    tick();
    alloc_valid_i = 1'b0; ROBupdateHead_i = 1'b0;
    check("ac_count", 78'(count_o), 78'd3);
    check("ac_head", 78'(ROBhead_o), 78'd3);
    check("ac_tail", 78'(alloc_tag_o), 78'd6);

    // Flush with five entries, concurrent alloc and wb
    alloc_valid_i = 1'b1;
    tick(); tick();
    alloc_valid_i = 1'b0;
    check("five_count", 78'(count_o), 78'd5);
    flush_i = 1'b1; alloc_valid_i = 1'b1; wb_valid_i = 1'b1; wb_tag_i = 5'd3; wb_data_i = 64'h99;
    tick();
    flush_i = 1'b0; alloc_valid_i = 1'b0; wb_valid_i = 1'b0;
    check("flush_count", 78'(count_o), 78'd0);
    check("flush_hvalid", 78'(headValid_o), 78'd0);
    check("flush_head", 78'(ROBhead_o), 78'd0);
    check("flush_tail", 78'(alloc_tag_o), 78'd0);
    check("flush_rdata", ROBcommitReadData_o, 78'd0);

    // Asynchronous reset with ten entries occupied
    alloc_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    alloc_valid_i = 1'b0;
    check("ten_count", 78'(count_o), 78'd10);
    #2 reset_i = 1'b0;
    #1;
    check("arst_count", 78'(count_o), 78'd0);
    check("arst_hvalid", 78'(headValid_o), 78'd0);
    check("arst_tag", 78'(alloc_tag_o), 78'd0);
    check("arst_ready", 78'(alloc_ready_o), 78'd1);
    check("arst_rdata", ROBcommitReadData_o, 78'd0);
    #3 reset_i = 1'b1;
    tick();
    alloc_valid_i = 1'b1;
    tick();
    alloc_valid_i = 1'b0;
    check("post_count", 78'(count_o), 78'd1);
    check("post_tag", 78'(alloc_tag_o), 78'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
